// File: rtl/run_ctrl_counters_pkg.sv
// Shared definitions for the run-control / performance-counter unit:
// run-state encoding and the readback-select width helper.
package run_ctrl_pkg;

    typedef logic [1:0] run_state_t;

    localparam run_state_t RUN    = 2'd0;
    localparam run_state_t PAUSED = 2'd1;
    localparam run_state_t HALTED = 2'd2;
    localparam run_state_t STEP   = 2'd3;

    // Select 0 is the cycle counter, 1..num_events are the event channels.
    function automatic int sel_width(input int num_events);
        return $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/run_ctrl_counters_event_counter.sv
// Single performance counter with synchronous clear, wrap or saturate on
// increment at all-ones, and a sticky overflow flag.
module event_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Clear beats a simultaneous increment.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&count_q) begin
                ovf_d   = 1'b1;
                count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/run_ctrl_counters.sv
// Run control (pause / single-step / syscall halt) producing the PC enable,
// plus gated cycle and event counters with registered channel readback.
module run_ctrl_counters
    import run_ctrl_pkg::*;
#(
    parameter int NUM_EVENTS  = 3,
    parameter int CNT_WIDTH   = 32,
    parameter int SATURATE    = 0,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = sel_width(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause_btn,
    input  logic                  step_btn,
    input  logic                  halt_req,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  clear,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic                  pc_enable,
    output logic [1:0]            run_state,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [NUM_EVENTS:0]   overflow
);

    logic [SYNC_STAGES-1:0] fill_q;
    logic [1:0]             btn_raw;
    logic [1:0]             btn_p;
    logic                   pause_p, step_p;

    assign btn_raw = {step_btn, pause_btn};

    // fill_q marks when the synchronisers hold real post-reset samples; until
    // then the edge detector keeps prev at 1 so a button held through reset
    // never produces a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fill_q <= '0;
        else      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
                prev_q <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[b]};
                prev_q <= fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
            end
        end

        assign btn_p[b] = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    assign pause_p = btn_p[0];
    assign step_p  = btn_p[1];

    run_state_t state_q, state_d;
    logic       ret_paused_q, ret_paused_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            ret_paused_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_paused_q <= ret_paused_d;
        end
    end

    // pause_p outranks step_p everywhere; halt_req only matters in RUN.
    always_comb begin
        state_d      = state_q;
        ret_paused_d = ret_paused_q;
        case (state_q)
            RUN: begin
                if (halt_req)     state_d = HALTED;
                else if (pause_p) state_d = PAUSED;
            end
            PAUSED: begin
                if (pause_p) begin
                    state_d = RUN;
                end else if (step_p) begin
                    state_d      = STEP;
                    ret_paused_d = 1'b1;
                end
            end
            HALTED: begin
                if (pause_p) begin
                    state_d      = STEP;
                    ret_paused_d = 1'b0;
                end else if (step_p) begin
                    state_d      = STEP;
                    ret_paused_d = 1'b1;
                end
            end
            STEP:    state_d = ret_paused_q ? PAUSED : RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_enable = ((state_q == RUN) && !halt_req) || (state_q == STEP);
        run_state = state_q;
    end

    logic [NUM_EVENTS:0]  inc;
    logic [CNT_WIDTH-1:0] cnt [NUM_EVENTS+1];

    // Channel 0 is the cycle counter; every channel is gated by pc_enable.
    assign inc = {events, 1'b1} & {(NUM_EVENTS + 1){pc_enable}};

    for (genvar i = 0; i <= NUM_EVENTS; i++) begin : g_cnt
        event_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[i]),
            .clear    (clear),
            .count    (cnt[i]),
            .overflow (overflow[i])
        );
    end

    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i <= NUM_EVENTS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_data_d = cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data_q <= '0;
        else      rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_run_ctrl_counters.sv
// Bench for run_ctrl_counters: a 32-bit wrap instance plus 4-bit wrap and
// saturate instances driven in lockstep and compared to a reference model.
module tb_run_ctrl_counters;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause_btn, step_btn, halt_req, clear;
    logic [3:0] ev;
    logic [2:0] sel;

    logic        pe_m, pe_w, pe_s;
    logic [1:0]  st_m, st_w, st_s;
    logic [31:0] rd_m;
    logic [3:0]  rd_w, rd_s;
    logic [3:0]  ovf_m;
    logic [4:0]  ovf_w, ovf_s;

    always #5 clk = ~clk;

    run_ctrl_counters #(.NUM_EVENTS(3), .CNT_WIDTH(32), .SATURATE(0), .SYNC_STAGES(SYNC)) u_main (
        .clk(clk), .rst(rst), .pause_btn(pause_btn), .step_btn(step_btn), .halt_req(halt_req),
        .events(ev[2:0]), .clear(clear), .rd_sel(sel[1:0]),
        .pc_enable(pe_m), .run_state(st_m), .rd_data(rd_m), .overflow(ovf_m)
    );

    run_ctrl_counters #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(0), .SYNC_STAGES(SYNC)) u_wrap (
        .clk(clk), .rst(rst), .pause_btn(pause_btn), .step_btn(step_btn), .halt_req(halt_req),
        .events(ev), .clear(clear), .rd_sel(sel),
        .pc_enable(pe_w), .run_state(st_w), .rd_data(rd_w), .overflow(ovf_w)
    );

    run_ctrl_counters #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1), .SYNC_STAGES(SYNC)) u_sat (
        .clk(clk), .rst(rst), .pause_btn(pause_btn), .step_btn(step_btn), .halt_req(halt_req),
        .events(ev), .clear(clear), .rd_sel(sel),
        .pc_enable(pe_s), .run_state(st_s), .rd_data(rd_s), .overflow(ovf_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts are unbounded "increments since clear", buttons
    // are a per-cycle history, and each instance's view is derived from them.
    int     m_state, m_ret, cyc;
    longint n [5];
    longint m_rd_m, m_rd_w, m_rd_s;
    bit     pb_h[$], sb_h[$];

    function automatic longint wrap4(input longint x);
        return x % 16;
    endfunction

    function automatic longint sat4(input longint x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ret = 0; cyc = 0;
        for (int i = 0; i < 5; i++) n[i] = 0;
        m_rd_m = 0; m_rd_w = 0; m_rd_s = 0;
        pb_h.delete(); sb_h.delete();
    endtask

    function automatic bit model_pe();
        return ((m_state == 0) && !halt_req) || (m_state == 3);
    endfunction

    task automatic check_outputs();
        logic [3:0] om;
        logic [4:0] ow;
        for (int i = 0; i < 4; i++) om[i] = (n[i] >= 64'h1_0000_0000);
        for (int i = 0; i < 5; i++) ow[i] = (n[i] >= 16);
        chk("pc_enable_main", pe_m, model_pe());
        chk("pc_enable_wrap", pe_w, model_pe());
        chk("pc_enable_sat", pe_s, model_pe());
        chk("run_state_main", st_m, m_state);
        chk("run_state_wrap", st_w, m_state);
        chk("run_state_sat", st_s, m_state);
        chk("rd_data_main", rd_m, m_rd_m);
        chk("rd_data_wrap", rd_w, m_rd_w);
        chk("rd_data_sat", rd_s, m_rd_s);
        chk("overflow_main", ovf_m, om);
        chk("overflow_wrap", ovf_w, ow);
        chk("overflow_sat", ovf_s, ow);
    endtask

    task automatic model_step();
        bit pe, pp, sp;
        int s;
        pe = model_pe();
        pp = (cyc >= SYNC + 1) && pb_h[cyc-SYNC] && !pb_h[cyc-SYNC-1];
        sp = (cyc >= SYNC + 1) && sb_h[cyc-SYNC] && !sb_h[cyc-SYNC-1];
        s = int'(sel);
        m_rd_m = n[sel[1:0]] & 64'hFFFF_FFFF;
        m_rd_w = (s <= 4) ? wrap4(n[s]) : 0;
        m_rd_s = (s <= 4) ? sat4(n[s]) : 0;
        if (clear) begin
            for (int i = 0; i < 5; i++) n[i] = 0;
        end else if (pe) begin
            n[0]++;
            for (int i = 0; i < 4; i++) if (ev[i]) n[i+1]++;
        end
        case (m_state)
            0: if (halt_req) m_state = 2; else if (pp) m_state = 1;
            1: if (pp) m_state = 0; else if (sp) begin m_state = 3; m_ret = 1; end
            2: if (pp) begin m_state = 3; m_ret = 0; end
               else if (sp) begin m_state = 3; m_ret = 1; end
            default: m_state = m_ret;
        endcase
        pb_h.push_back(pause_btn);
        sb_h.push_back(step_btn);
        cyc++;
    endtask

    task automatic drive(input bit p, input bit s, input bit h, input logic [3:0] e,
                         input bit c, input logic [2:0] sl);
        pause_btn = p; step_btn = s; halt_req = h; ev = e; clear = c; sel = sl;
        #1;
    endtask

    task automatic finish_cycle();
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic run_cycle(input bit p, input bit s, input bit h, input logic [3:0] e,
                             input bit c, input logic [2:0] sl);
        drive(p, s, h, e, c, sl);
        finish_cycle();
    endtask

    task automatic do_reset(input bit hold_pause);
        rst = 1'b0;
        pause_btn = hold_pause; step_btn = 0; halt_req = 0; ev = 0; clear = 0; sel = 0;
        repeat (2) @(negedge clk);
        chk("reset_pc_enable", pe_m, 1);
        chk("reset_state", st_m, 0);
        chk("reset_rd_data", rd_m, 0);
        chk("reset_overflow", ovf_m, 0);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         p, s, h;
        logic [3:0] e;
        bit         c;
        logic [2:0] sl;
        bit         exp_pe;
        int         exp_st;
        bit         chk_rd;
        longint     exp_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit p, input bit s, input bit h, input logic [3:0] e, input bit c,
                       input logic [2:0] sl, input bit xpe, input int xst, input bit crd,
                       input longint xrd);
        vec_t v;
        v = '{p, s, h, e, c, sl, xpe, xst, crd, xrd};
        tbl.push_back(v);
    endtask

    initial begin
        // Held pause button through reset must not pause once released.
        do_reset(1'b1);
        repeat (5) run_cycle(1, 0, 0, 0, 0, 0);
        repeat (4) run_cycle(0, 0, 0, 0, 0, 0);
        chk("held_btn_no_pause", st_m, 0);

        // Directed vectors: events while running then paused, three steps,
        // simultaneous pause+step, halt and step-past-syscall.
        add(0,0,0,0,1,1, 1,0,0,0);
        for (int i = 0; i < 10; i++) add(0,0,0,4'b0001,0,1, 1,0,0,0);
        add(1,0,0,0,0,1, 1,0,0,0);
        add(1,0,0,0,0,1, 1,0,1,10);
        add(1,0,0,0,0,1, 1,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,4'b0001,0,1, 0,1,0,0);
        add(0,0,0,0,0,1, 0,1,1,10);
        add(0,0,0,0,0,0, 0,1,1,10);
        add(0,0,0,0,0,0, 0,1,1,13);
        for (int k = 0; k < 3; k++) begin
            add(0,1,0,0,0,0, 0,1,0,0);
            add(0,0,0,0,0,0, 0,1,0,0);
            add(0,0,0,0,0,0, 0,1,0,0);
            add(0,0,0,0,0,0, 1,3,0,0);
        end
        add(0,0,0,0,0,0, 0,1,1,15);
        add(0,0,0,0,0,0, 0,1,1,16);
        add(1,1,0,0,0,0, 0,1,0,0);
        add(0,0,0,0,0,0, 0,1,0,0);
        add(0,0,0,0,0,0, 0,1,0,0);
        add(0,0,0,0,0,0, 1,0,1,16);
        add(0,0,1,0,0,0, 0,0,1,16);
        add(1,0,1,0,0,0, 0,2,1,17);
        add(0,0,1,0,0,0, 0,2,0,0);
        add(0,0,1,0,0,0, 0,2,0,0);
        add(0,0,1,0,0,0, 1,3,0,0);
        add(0,0,0,0,0,0, 1,0,0,0);
        add(0,0,0,0,0,0, 1,0,1,18);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].p, tbl[i].s, tbl[i].h, tbl[i].e, tbl[i].c, tbl[i].sl);
            chk($sformatf("tbl%0d_pe", i), pe_m, tbl[i].exp_pe);
            chk($sformatf("tbl%0d_state", i), st_m, tbl[i].exp_st);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rd_m, tbl[i].exp_rd);
            finish_cycle();
        end

        // Narrow counters: 17 increments wrap to 1 / saturate at 15.
        run_cycle(0, 0, 0, 0, 1, 1);
        repeat (17) run_cycle(0, 0, 0, 4'b0001, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap4_ovf1", ovf_w[1], 1);
        chk("sat4_ovf1", ovf_s[1], 1);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap4_count17", rd_w, 1);
        chk("sat4_count17", rd_s, 15);
        chk("main_count17", rd_m, 17);
        finish_cycle();

        // Clear coinciding with the 17th increment.
        run_cycle(0, 0, 0, 0, 1, 1);
        repeat (16) run_cycle(0, 0, 0, 4'b0001, 0, 1);
        drive(0, 0, 0, 4'b0001, 1, 1);
        chk("wrap4_ovf_before_clear", ovf_w[1], 1);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap4_ovf_cleared", ovf_w, 0);
        chk("sat4_ovf_cleared", ovf_s, 0);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap4_count_cleared", rd_w, 0);
        chk("sat4_count_cleared", rd_s, 0);
        finish_cycle();

        // Out-of-range select reads 0, one edge after the select changes.
        repeat (3) run_cycle(0, 0, 0, 4'b0001, 0, 1);
        drive(0, 0, 0, 0, 0, 5);
        chk("sel_change_not_yet", rd_w, 2);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 5);
        chk("sel_out_of_range_wrap", rd_w, 0);
        chk("sel_out_of_range_sat", rd_s, 0);
        finish_cycle();

        // Randomised traffic against the model.
        begin
            bit p = 0, s = 0, h = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 5) == 0) p = ~p;
                if ($urandom_range(0, 5) == 0) s = ~s;
                if ($urandom_range(0, 9) == 0) h = ~h;
                run_cycle(p, s, h, 4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0),
                          3'($urandom_range(0, 7)));
            end
        end

        // Asynchronous reset in the middle of a STEP cycle.
        do_reset(1'b0);
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 1, 0, 0, 0);
        run_cycle(0, 1, 1, 0, 0, 0);
        run_cycle(0, 0, 1, 0, 0, 0);
        run_cycle(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("pre_reset_in_step", st_m, 3);
        chk("pre_reset_step_pe", pe_m, 1);
        chk("pre_reset_rd", rd_m, 3);
        #2;
        rst = 1'b0;
        halt_req = 1'b0;
        #1;
        chk("async_reset_state", st_m, 0);
        chk("async_reset_pe", pe_m, 1);
        chk("async_reset_rd", rd_m, 0);
        chk("async_reset_ovf", ovf_w, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (6) run_cycle(0, 0, 0, 4'b0011, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
